// File: rtl/neuralnet_pkg.sv
// -----------------------------------------------------------------------------
// neuralnet_pkg
// Shared types and default constants for the neural-net weight path.
//   load_state_t : weight-loader frame state (IDLE / LOAD / FULL)
//   GPIO_DATA_W  : default byte width of the Raspberry Pi GPIO bus
//   LED_W        : default number of board LEDs
// -----------------------------------------------------------------------------
package neuralnet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } load_state_t;

    localparam int GPIO_DATA_W = 8;
    localparam int LED_W       = 6;

endpackage : neuralnet_pkg

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects strobed bytes little-endian into a WORD_BYTES-wide word.
// Ports:
//   pi_clk       in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   i_clear      in   drop the partial word and restart at lane 0
//   i_strobe     in   capture i_byte into the current lane
//   i_byte       in   byte to capture
//   o_word       out  assembled word including the byte being strobed now
//   o_word_ready out  high while the strobe completes a word (commit now)
// -----------------------------------------------------------------------------
module word_assembler #(
    parameter int DATA_W     = 8,
    parameter int WORD_BYTES = 2
) (
    input  logic                           pi_clk,
    input  logic                           rst,
    input  logic                           i_clear,
    input  logic                           i_strobe,
    input  logic [DATA_W-1:0]              i_byte,
    output logic [DATA_W*WORD_BYTES-1:0]   o_word,
    output logic                           o_word_ready
);

    localparam int WORD_W = DATA_W * WORD_BYTES;
    localparam int IW     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);

    logic [IW-1:0]     r_byte_idx;
    logic [WORD_W-1:0] r_lanes;
    logic              w_last;

    assign w_last = (r_byte_idx == LAST_IDX);

    // The word is presented combinationally with the incoming byte merged in,
    // so the owner can commit on the same edge that captures the last byte.
    always_comb begin
        o_word = r_lanes;
        o_word[int'(r_byte_idx) * DATA_W +: DATA_W] = i_byte;
    end

    assign o_word_ready = i_strobe & ~i_clear & w_last;

    // Lane register and byte index; a completed word restarts at lane 0.
    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            r_byte_idx <= '0;
            r_lanes    <= '0;
        end else if (i_clear) begin
            r_byte_idx <= '0;
            r_lanes    <= '0;
        end else if (i_strobe) begin
            if (w_last) begin
                r_byte_idx <= '0;
                r_lanes    <= '0;
            end else begin
                r_byte_idx <= r_byte_idx + IW'(1);
                r_lanes    <= o_word;
            end
        end else begin
            r_byte_idx <= r_byte_idx;
            r_lanes    <= r_lanes;
        end
    end

endmodule : word_assembler

// File: rtl/gpio_weight_loader.sv
// -----------------------------------------------------------------------------
// gpio_weight_loader
// Captures GPIO bytes into words, stores them into a DEPTH-entry weight array
// under frame control and serves a registered read port to the NN core.
// Ports:
//   pi_clk, rst           clock / asynchronous active-high reset
//   gpio_pin, write_enable byte from the Pi and its per-cycle strobe
//   frame_start           begin or restart a load frame (wins over a strobe)
//   rd_en, rd_addr        read request; out-of-range addresses return 0
//   rd_data, rd_valid     read result, one cycle after rd_en
//   word_count            words committed in this frame
//   loaded, load_done     FULL level / one-cycle frame-complete pulse
//   overflow              sticky: byte strobed while FULL
//   LED                   low bits of the last word read, held
// -----------------------------------------------------------------------------
module gpio_weight_loader #(
    parameter int DATA_W     = neuralnet_pkg::GPIO_DATA_W,
    parameter int WORD_BYTES = 2,
    parameter int DEPTH      = 16,
    parameter int LED_W      = neuralnet_pkg::LED_W
) (
    input  logic                                  pi_clk,
    input  logic                                  rst,
    input  logic [DATA_W-1:0]                     gpio_pin,
    input  logic                                  write_enable,
    input  logic                                  frame_start,
    input  logic                                  rd_en,
    input  logic [$clog2(DEPTH)-1:0]              rd_addr,
    output logic [DATA_W*WORD_BYTES-1:0]          rd_data,
    output logic                                  rd_valid,
    output logic [$clog2(DEPTH):0]                word_count,
    output logic                                  loaded,
    output logic                                  load_done,
    output logic                                  overflow,
    output logic [LED_W-1:0]                      LED
);

    import neuralnet_pkg::*;

    localparam int WORD_W = DATA_W * WORD_BYTES;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

    load_state_t       r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_word_count;
    logic              r_loaded;
    logic              r_load_done;
    logic              r_overflow;
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [LED_W-1:0]  r_led;

    logic              w_strobe;
    logic              w_commit;
    logic [WORD_W-1:0] w_word;
    logic              w_rd_in_range;
    logic [WORD_W-1:0] w_rd_word;

    // Bytes are only accepted while loading; frame_start drops a same-cycle byte.
    assign w_strobe = write_enable & ~frame_start & (r_state == LOAD);

    word_assembler #(
        .DATA_W     (DATA_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_word_assembler (
        .pi_clk       (pi_clk),
        .rst          (rst),
        .i_clear      (frame_start),
        .i_strobe     (w_strobe),
        .i_byte       (gpio_pin),
        .o_word       (w_word),
        .o_word_ready (w_commit)
    );

    // Frame FSM with pointer, count and status flags.
    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_loaded     <= 1'b0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (frame_start) begin
                r_state      <= LOAD;
                r_wr_ptr     <= '0;
                r_word_count <= '0;
                r_loaded     <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    LOAD: begin
                        if (w_commit) begin
                            r_word_count <= r_word_count + (AW + 1)'(1);
                            // The last slot ends the frame; the pointer parks there.
                            if (r_wr_ptr == LAST_PTR) begin
                                r_state     <= FULL;
                                r_loaded    <= 1'b1;
                                r_load_done <= 1'b1;
                            end else begin
                                r_wr_ptr <= r_wr_ptr + AW'(1);
                            end
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                    FULL: begin
                        if (write_enable) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_overflow <= r_overflow;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_loaded <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Weight array; contents survive frame_start and clear only on reset.
    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_wr_ptr] <= w_word;
        end else begin
            r_mem <= r_mem;
        end
    end

    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

    // Read mux; a same-cycle commit is not visible until the next read.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr];
        end else begin
            w_rd_word = '0;
        end
    end

    // Registered read port; data and LEDs hold between reads.
    always_ff @(posedge pi_clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_led      <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
                r_led     <= w_rd_word[LED_W-1:0];
            end else begin
                r_rd_data <= r_rd_data;
                r_led     <= r_led;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign word_count = r_word_count;
    assign loaded     = r_loaded;
    assign load_done  = r_load_done;
    assign overflow   = r_overflow;
    assign LED        = r_led;

endmodule : gpio_weight_loader

// File: tb/tb_gpio_weight_loader.sv
module tb_gpio_weight_loader;

    localparam int DEPTH = 16;
    localparam int WB    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  gpio;
    logic        we;
    logic        fs;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic [15:0] rd_data,  rd_data2;
    logic        rd_valid, rd_valid2;
    logic [4:0]  wcnt,     wcnt2;
    logic        loaded,   loaded2;
    logic        ldone,    ldone2;
    logic        ovf,      ovf2;
    logic [5:0]  led,      led2;

    int total = 0;
    int bad   = 0;
    int ld_cnt = 0;

    // behavioural model: 0 = IDLE, 1 = LOAD, 2 = FULL
    int          m_state;
    logic [7:0]  m_q[$];
    int          m_wptr;
    int          m_cnt;
    bit          m_ovf;
    logic [15:0] m_mem [DEPTH];

    always #5 clk = ~clk;

    gpio_weight_loader dut (
        .pi_clk(clk), .rst(rst), .gpio_pin(gpio), .write_enable(we),
        .frame_start(fs), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .word_count(wcnt),
        .loaded(loaded), .load_done(ldone), .overflow(ovf), .LED(led)
    );

    gpio_weight_loader #(.DEPTH(12)) dut12 (
        .pi_clk(clk), .rst(rst), .gpio_pin(gpio), .write_enable(we),
        .frame_start(fs), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .word_count(wcnt2),
        .loaded(loaded2), .load_done(ldone2), .overflow(ovf2), .LED(led2)
    );

    always @(negedge clk) begin
        if (ldone === 1'b1) ld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_state = 0; m_q.delete(); m_wptr = 0; m_cnt = 0; m_ovf = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 16'h0000;
    endtask

    task automatic m_frame();
        m_state = 1; m_q.delete(); m_wptr = 0; m_cnt = 0; m_ovf = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [15:0] w;
        if (m_state == 1) begin
            m_q.push_back(b);
            if (m_q.size() == WB) begin
                w = 16'h0000;
                for (int k = 0; k < WB; k++) w = w | (16'(m_q[k]) << (8 * k));
                m_mem[m_wptr] = w;
                m_cnt++;
                if (m_cnt == DEPTH) m_state = 2;
                else m_wptr++;
                m_q.delete();
            end
        end else if (m_state == 2) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic frame_start(input bit with_byte, input logic [7:0] b);
        fs = 1'b1; we = with_byte; gpio = b;
        tick();
        fs = 1'b0; we = 1'b0;
        m_frame();
    endtask

    task automatic strobe(input logic [7:0] b);
        gpio = b; we = 1'b1;
        tick();
        we = 1'b0;
        m_byte(b);
    endtask

    task automatic read(input string tag, input logic [3:0] a);
        logic [15:0] exp;
        exp = (int'(a) < DEPTH) ? m_mem[a] : 16'h0000;
        rd_addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic [15:0] old3;
        rst = 1'b1; gpio = 8'h00; we = 1'b0; fs = 1'b0; rd_en = 1'b0; rd_addr = 4'd0;
        m_reset();
        tick(); tick();
        check("rst_rd_data",  32'(rd_data),  32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wcnt",     32'(wcnt),     32'd0);
        check("rst_loaded",   32'(loaded),   32'd0);
        check("rst_ldone",    32'(ldone),    32'd0);
        check("rst_ovf",      32'(ovf),      32'd0);
        check("rst_led",      32'(led),      32'd0);
        rst = 1'b0;
        tick();

        // bytes in IDLE are ignored
        strobe(8'h11); strobe(8'h22); strobe(8'h33);
        check("idle_wcnt", 32'(wcnt), 32'd0);
        read("idle_mem0", 4'd0);
        tick();
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);

        // partial word after a full one
        frame_start(1'b0, 8'h00);
        strobe(8'hAA); strobe(8'hBB); strobe(8'hCC);
        check("abc_wcnt", 32'(wcnt), 32'd1);
        read("abc_mem0", 4'd0);

        // full frame 0x01..0x20
        ld_cnt = 0;
        frame_start(1'b0, 8'h00);
        for (int i = 1; i <= 31; i++) strobe(8'(i));
        check("pre_loaded", 32'(loaded), 32'd0);
        check("pre_ldone",  32'(ldone),  32'd0);
        strobe(8'h20);
        check("ldone_hi",  32'(ldone),  32'd1);
        check("loaded",    32'(loaded), 32'd1);
        check("full_wcnt", 32'(wcnt),   32'(m_cnt));
        check("full_wcnt16", 32'(wcnt), 32'd16);
        tick();
        check("ldone_lo",  32'(ldone),  32'd0);
        check("ldone_cnt", 32'(ld_cnt), 32'd1);
        read("mem0", 4'd0);
        check("mem0_const", 32'(rd_data), 32'h0201);
        check("d12_mem0", 32'(rd_data2), 32'h0201);
        read("mem15", 4'd15);
        check("mem15_const", 32'(rd_data), 32'h201F);
        read("mem13", 4'd13);
        check("d12_oor", 32'(rd_data2), 32'd0);
        check("d12_loaded", 32'(loaded2), 32'd1);
        check("d12_ovf",    32'(ovf2),    32'd1);
        check("d12_wcnt",   32'(wcnt2),   32'd12);

        // overflow while FULL
        strobe(8'h55);
        check("ovf_set", 32'(ovf), 32'(m_ovf));
        read("ovf_mem15", 4'd15);
        read("ovf_mem0", 4'd0);
        frame_start(1'b0, 8'h00);
        check("ovf_clr",   32'(ovf),    32'd0);
        check("fs_wcnt",   32'(wcnt),   32'd0);
        check("fs_loaded", 32'(loaded), 32'd0);

        // restart mid-frame with a colliding strobe
        strobe(8'hA0); strobe(8'hA1); strobe(8'hA2); strobe(8'hA3); strobe(8'hA4);
        frame_start(1'b1, 8'h77);
        strobe(8'h10); strobe(8'h11);
        check("restart_wcnt", 32'(wcnt), 32'd1);
        read("restart_mem0", 4'd0);
        check("restart_mem0_const", 32'(rd_data), 32'h1110);
        read("restart_mem1", 4'd1);

        // read and commit to word 3 in the same cycle
        strobe(8'h20); strobe(8'h21); strobe(8'h22); strobe(8'h23); strobe(8'h24);
        old3 = m_mem[3];
        gpio = 8'h25; we = 1'b1; rd_addr = 4'd3; rd_en = 1'b1;
        tick();
        we = 1'b0; rd_en = 1'b0;
        m_byte(8'h25);
        check("rw_valid", 32'(rd_valid), 32'd1);
        check("rw_old",   32'(rd_data),  32'(old3));
        check("rw_old_const", 32'(rd_data), 32'h0807);
        check("rw_wcnt",  32'(wcnt),     32'd4);
        read("rw_new", 4'd3);
        check("rw_led", 32'(led), 32'(m_mem[3][5:0]));

        // random full frame against the model
        frame_start(1'b0, 8'h00);
        for (int i = 0; i < DEPTH * WB; i++) strobe(8'($urandom_range(0, 255)));
        check("rnd_loaded", 32'(loaded), 32'(m_state == 2));
        for (int a = 0; a < DEPTH; a++) read("rnd_mem", 4'(a));
        for (int i = 0; i < 8; i++) begin
            read("rnd_rd", 4'($urandom_range(0, DEPTH - 1)));
            check("rnd_led", 32'(led), 32'(rd_data[5:0]));
        end

        // asynchronous reset mid-frame at byte 9
        frame_start(1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) strobe(8'(8'h80 + i));
        read("pre_rst_mem0", 4'd0);
        gpio = 8'h89; we = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        we = 1'b0;
        m_reset();
        check("arst_rd_data", 32'(rd_data), 32'd0);
        check("arst_led",     32'(led),     32'd0);
        check("arst_wcnt",    32'(wcnt),    32'd0);
        check("arst_loaded",  32'(loaded),  32'd0);
        check("arst_ovf",     32'(ovf),     32'd0);
        check("arst_valid",   32'(rd_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) read("arst_mem", 4'(a));
        strobe(8'h5A); strobe(8'h5B);
        check("arst_idle_wcnt", 32'(wcnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gpio_weight_loader
